// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared constants, state type and step helper for the selector sequencer
package conv_sched_pkg;

    localparam int CNT_MAX = 32;
    localparam int POS_MAX = 9;
    localparam int CNT_W   = 5;
    localparam int POS_W   = 4;
    localparam int NF_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    // The last step of a pass sequence is the one on which the selector reloads its frame register
    function automatic logic is_load_step(input logic [CNT_W-1:0] cnt, input logic [POS_W-1:0] pos);
        return (cnt == CNT_W'(CNT_MAX - 1)) && (pos == POS_W'(POS_MAX - 1));
    endfunction

endpackage

// File: rtl/conv_step_counter.sv
// rtl/conv_step_counter.sv - nested pos (inner) / cnt (outer) step counter with wrap flag
module conv_step_counter
    import conv_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             advance,
    output logic [CNT_W-1:0] cnt,
    output logic [POS_W-1:0] pos,
    output logic             wrap
);

    // The wrap step is the frame-load step, so callers use it to act on frame boundaries
    assign wrap = advance && is_load_step(cnt, pos);

    // Step the pair on advance: pos wraps first, carrying into cnt; both wrap together at the end
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
            pos <= '0;
        end else if (advance) begin
            if (pos == POS_W'(POS_MAX - 1)) begin
                pos <= '0;
                if (cnt == CNT_W'(CNT_MAX - 1)) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                pos <= pos + POS_W'(1);
            end
        end
    end

endmodule

// File: rtl/conv_select_sched.sv
// rtl/conv_select_sched.sv - en/cnt/pos step sequencer for the 14x10 window selector
module conv_select_sched
    import conv_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [NF_W-1:0]  num_frames,
    input  logic             frame_valid,
    output logic             frame_ack,
    input  logic             down_ready,
    output logic             sel_en,
    output logic [CNT_W-1:0] sel_cnt,
    output logic [POS_W-1:0] sel_pos,
    output logic             res_valid,
    output logic             res_last,
    output logic             busy,
    output logic             done
);

    sched_state_t     state;
    sched_state_t     state_n;
    logic [NF_W-1:0]  frames_left;
    logic [CNT_W-1:0] cnt;
    logic [POS_W-1:0] pos;
    logic             wrap;
    logic             issue;
    logic             at_load;
    logic             final_frame;
    logic             last_step;

    conv_step_counter u_step (
        .clk     (clk),
        .rst_b   (rst_b),
        .advance (issue),
        .cnt     (cnt),
        .pos     (pos),
        .wrap    (wrap)
    );

    assign at_load     = is_load_step(cnt, pos);
    assign final_frame = (frames_left == NF_W'(1));
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and step issue; a load step of a non-final frame also needs the next frame present
    always_comb begin
        state_n   = state;
        sel_en    = 1'b0;
        frame_ack = 1'b0;
        sel_cnt   = cnt;
        sel_pos   = pos;
        issue     = 1'b0;
        last_step = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (num_frames == '0) ? DONE : PRIME;
                end
            end
            PRIME: begin
                sel_cnt = CNT_W'(CNT_MAX - 1);
                sel_pos = POS_W'(POS_MAX - 1);
                if (frame_valid) begin
                    sel_en    = 1'b1;
                    frame_ack = 1'b1;
                    state_n   = RUN;
                end
            end
            RUN: begin
                issue  = down_ready && (!at_load || final_frame || frame_valid);
                sel_en = issue;
                if (wrap) begin
                    if (final_frame) begin
                        last_step = 1'b1;
                        state_n   = DONE;
                    end else begin
                        frame_ack = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Batch frame counter: loaded on an accepted start, consumed by each mid-batch frame load
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            frames_left <= '0;
        end else if (state == IDLE && start && num_frames != '0) begin
            frames_left <= num_frames;
        end else if (state == RUN && wrap && !final_frame) begin
            frames_left <= frames_left - NF_W'(1);
        end
    end

    // Result flags lag the issued step by one cycle to line up with the selector outputs
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
        end else begin
            res_valid <= issue;
            res_last  <= last_step;
        end
    end

endmodule

// File: tb/tb_conv_select_sched.sv
// tb/tb_conv_select_sched.sv - randomized and table-driven bench for conv_select_sched
module tb_conv_select_sched;

    localparam int STEPS = 32 * 9;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       start = 1'b0;
    logic [7:0] num_frames = '0;
    logic       frame_valid = 1'b0;
    logic       frame_ack;
    logic       down_ready = 1'b0;
    logic       sel_en;
    logic [4:0] sel_cnt;
    logic [3:0] sel_pos;
    logic       res_valid;
    logic       res_last;
    logic       busy;
    logic       done;

    conv_select_sched dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (start),
        .num_frames  (num_frames),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .down_ready  (down_ready),
        .sel_en      (sel_en),
        .sel_cnt     (sel_cnt),
        .sel_pos     (sel_pos),
        .res_valid   (res_valid),
        .res_last    (res_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 stepping, 2 done pulse; k = index of the pending step in the batch
    int m_phase = 0;
    int m_k     = 0;
    int m_n     = 0;
    bit m_rv    = 0;
    bit m_rl    = 0;

    int c_en, c_ack, c_rv, c_rl, c_done;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Step k=0 is the prime load; step k>=1 is element (k-1) mod 288 of frame (k-1)/288
    task automatic pending(output int c, output int p, output bit ld, output bit fin);
        int idx;
        if (m_k == 0) begin
            c = 31; p = 8; ld = 1; fin = 0;
        end else begin
            idx = (m_k - 1) % STEPS;
            c   = idx / 9;
            p   = idx % 9;
            ld  = (idx == STEPS - 1);
            fin = ((m_k - 1) / STEPS) == (m_n - 1);
        end
    endtask

    // One clock: check outputs against the model for current inputs, then advance both
    task automatic step();
        int c, p;
        bit ld, fin, iss, ack, e_busy, e_done;
        c = 0; p = 0; ld = 0; fin = 0; iss = 0; ack = 0; e_busy = 0; e_done = 0;
        if (m_phase == 1) begin
            pending(c, p, ld, fin);
            e_busy = 1;
            if (m_k == 0) iss = frame_valid;
            else          iss = down_ready && (!ld || fin || frame_valid);
            ack = iss && ld && (m_k == 0 || !fin);
        end else if (m_phase == 2) begin
            e_busy = 1;
            e_done = 1;
        end
        #1;
        chk("sel_en", sel_en, iss);
        chk("frame_ack", frame_ack, ack);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("res_valid", res_valid, m_rv);
        chk("res_last", res_last, m_rl);
        if (iss || m_phase != 1) begin
            chk("sel_cnt", sel_cnt, c);
            chk("sel_pos", sel_pos, p);
        end
        c_en   += sel_en;
        c_ack  += frame_ack;
        c_rv   += res_valid;
        c_rl   += res_last;
        c_done += done;
        @(posedge clk);
        case (m_phase)
            0: begin
                m_rv = 0; m_rl = 0;
                if (start) begin
                    m_n = num_frames;
                    m_k = 0;
                    m_phase = (num_frames == 0) ? 2 : 1;
                end
            end
            1: begin
                m_rv = iss && (m_k > 0);
                m_rl = iss && (m_k == m_n * STEPS);
                if (iss) begin
                    if (m_k == m_n * STEPS) m_phase = 2;
                    m_k++;
                end
            end
            default: begin
                m_rv = 0; m_rl = 0;
                m_phase = 0;
            end
        endcase
        #1;
    endtask

    task automatic clear_counts();
        c_en = 0; c_ack = 0; c_rv = 0; c_rl = 0; c_done = 0;
    endtask

    task automatic drive(input int rmode, input int vmode, input bit noise, inout bit tog);
        tog = !tog;
        down_ready  = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(0, 1));
        frame_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        start       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        num_frames  = noise ? 8'($urandom_range(0, 4)) : num_frames;
    endtask

    task automatic run_batch(input int nf, input int rmode, input int vmode, input bit noise);
        bit tog;
        int budget;
        tog = 0;
        budget = 0;
        start = 1; num_frames = 8'(nf); down_ready = 1; frame_valid = 1;
        step();
        while (m_phase != 0 && budget < 5000) begin
            drive(rmode, vmode, noise, tog);
            step();
            budget++;
        end
        start = 0;
        if (m_phase != 0) chk("batch_timeout", budget, -1);
    endtask

    typedef struct {
        int nf;
        int rmode;
        int vmode;
        bit noise;
        int e_en;
        int e_ack;
        int e_rv;
        int e_rl;
        int e_done;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1, 0, 0, 0, 289, 1, 288, 1, 1};
        vecs[1] = '{2, 0, 0, 0, 577, 2, 576, 1, 1};
        vecs[2] = '{0, 0, 0, 0,   0, 0,   0, 0, 1};
        vecs[3] = '{1, 1, 0, 0, 289, 1, 288, 1, 1};
        vecs[4] = '{3, 2, 2, 1, 865, 3, 864, 1, 1};
        vecs[5] = '{2, 2, 0, 1, 577, 2, 576, 1, 1};

        // Reset state
        #2;
        chk("rst_sel_en", sel_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_frame_ack", frame_ack, 0);
        @(posedge clk);
        #1;
        rst_b = 1;
        step();
        step();

        // Table-driven batches with per-cycle model checking
        for (int i = 0; i < 6; i++) begin
            clear_counts();
            run_batch(vecs[i].nf, vecs[i].rmode, vecs[i].vmode, vecs[i].noise);
            chk($sformatf("v%0d_en_total", i), c_en, vecs[i].e_en);
            chk($sformatf("v%0d_ack_total", i), c_ack, vecs[i].e_ack);
            chk($sformatf("v%0d_rv_total", i), c_rv, vecs[i].e_rv);
            chk($sformatf("v%0d_rl_total", i), c_rl, vecs[i].e_rl);
            chk($sformatf("v%0d_done_total", i), c_done, vecs[i].e_done);
            step();
        end

        // Frame starvation at the mid-batch load step (31,8)
        begin
            int budget;
            clear_counts();
            start = 1; num_frames = 2; down_ready = 1; frame_valid = 1;
            step();
            start = 0;
            budget = 0;
            while (!(m_phase == 1 && m_k == STEPS) && budget < 1000) begin
                step();
                budget++;
            end
            chk("starve_reach", m_k, STEPS);
            frame_valid = 0;
            for (int s = 0; s < 5; s++) begin
                #1;
                chk("starve_en", sel_en, 0);
                chk("starve_cnt", sel_cnt, 31);
                chk("starve_pos", sel_pos, 8);
                chk("starve_ack", frame_ack, 0);
                #0 ;
                step();
                budget = budget;
            end
            chk("starve_rv_after", res_valid, 0);
            frame_valid = 1;
            budget = 0;
            while (m_phase != 0 && budget < 2000) begin
                step();
                budget++;
            end
            chk("starve_en_total", c_en, 577);
            chk("starve_ack_total", c_ack, 2);
            chk("starve_rv_total", c_rv, 576);
            chk("starve_rl_total", c_rl, 1);
        end

        // Async reset mid-run at step (10,4), then a clean restart
        begin
            int budget;
            start = 1; num_frames = 1; down_ready = 1; frame_valid = 1;
            step();
            start = 0;
            budget = 0;
            while (!(m_phase == 1 && m_k == 1 + 10 * 9 + 4) && budget < 1000) begin
                step();
                budget++;
            end
            #1;
            chk("pre_rst_cnt", sel_cnt, 10);
            chk("pre_rst_pos", sel_pos, 4);
            #1;
            rst_b = 0;
            #1;
            chk("mid_rst_en", sel_en, 0);
            chk("mid_rst_cnt", sel_cnt, 0);
            chk("mid_rst_pos", sel_pos, 0);
            chk("mid_rst_rv", res_valid, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_ack", frame_ack, 0);
            chk("mid_rst_done", done, 0);
            chk("mid_rst_rl", res_last, 0);
            @(posedge clk);
            #1;
            rst_b = 1;
            m_phase = 0; m_k = 0; m_rv = 0; m_rl = 0;
            step();
            clear_counts();
            run_batch(1, 0, 0, 0);
            chk("restart_en_total", c_en, 289);
            chk("restart_rv_total", c_rv, 288);
        end

        // Randomized batches against the model
        for (int r = 0; r < 4; r++) begin
            int nf;
            nf = $urandom_range(0, 3);
            clear_counts();
            run_batch(nf, 2, 2, 1);
            chk("rand_en_total", c_en, (nf == 0) ? 0 : 1 + nf * STEPS);
            chk("rand_rv_total", c_rv, nf * STEPS);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
